// File: rtl/divider_pkg.sv
// Shared types and constants for the multi-cycle DIV/IDIV unit.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        DIVIDE = 2'd2,
        FIX    = 2'd3
    } DivState_t;

    // Interrupt vector the microcode takes when the divider reports an error.
    localparam logic [7:0] DIV_ERROR_VECTOR = 8'h00;

endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] div_ext;

    assign shifted = {rem_i[WIDTH-1:0], bit_i};
    assign div_ext = {1'b0, div_i};

    // A set top bit means the shifted value already exceeds any divisor.
    assign q_o   = rem_i[WIDTH] | (shifted >= div_ext);
    assign rem_o = q_o ? (shifted - div_ext) : shifted;

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider with 8086 DIV/IDIV semantics: 2*WIDTH-bit dividend,
// WIDTH-bit divisor, divide error on zero divisor or quotient overflow.
module iterative_divider
    import divider_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output DivState_t          state_o
);

    // Handshake: start is sampled only while idle; busy is high for the whole
    // operation; done pulses one cycle with busy low and results valid, and a new
    // start may be presented in that same cycle.

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    DivState_t          state_q, state_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   dmag_q, dmag_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rmd_q, rmd_d;

    logic               a_neg, d_neg, q_neg, early_err, q_ovf;
    logic [2*WIDTH-1:0] a_mag;
    logic [WIDTH-1:0]   d_mag;

    assign a_neg     = sgn_q & dvd_q[2*WIDTH-1];
    assign d_neg     = sgn_q & dvs_q[WIDTH-1];
    assign q_neg     = a_neg ^ d_neg;
    assign a_mag     = a_neg ? -dvd_q : dvd_q;
    assign d_mag     = d_neg ? -dvs_q : dvs_q;
    // Upper half >= divisor means the quotient cannot fit; also catches divisor 0.
    assign early_err = a_mag[2*WIDTH-1:WIDTH] >= d_mag;
    assign q_ovf     = sgn_q & (lo_q > MAX_POS);

    logic [BITS_PER_CYCLE:0][WIDTH:0] rem_chain;
    logic [BITS_PER_CYCLE-1:0]        q_bits;
    logic [WIDTH-1:0]                 lo_next;

    assign rem_chain[0] = rem_q;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_chain[k]),
            .bit_i (lo_q[WIDTH-1-k]),
            .div_i (dmag_q),
            .rem_o (rem_chain[k+1]),
            .q_o   (q_bits[BITS_PER_CYCLE-1-k])
        );
    end

    // Dividend bits leave lo_q at the top while quotient bits enter at the bottom.
    if (BITS_PER_CYCLE < WIDTH) begin : g_lo_shift
        assign lo_next = {lo_q[WIDTH-1-BITS_PER_CYCLE:0], q_bits};
    end else begin : g_lo_full
        assign lo_next = q_bits;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            lo_q    <= '0;
            dmag_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dmag_q  <= dmag_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            error_q <= error_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dmag_d  = dmag_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        error_d = error_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sgn_d   = is_signed;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (early_err) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    rem_d   = {1'b0, a_mag[2*WIDTH-1:WIDTH]};
                    lo_d    = a_mag[WIDTH-1:0];
                    dmag_d  = d_mag;
                    cnt_d   = CW'(N - 1);
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = rem_chain[BITS_PER_CYCLE];
                lo_d  = lo_next;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                // -2^(WIDTH-1) is deliberately rejected, matching 8086 IDIV.
                error_d = q_ovf;
                if (!q_ovf) begin
                    quot_d = q_neg ? -lo_q : lo_q;
                    rmd_d  = a_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign state_o   = state_q;

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Parametrised multi-cycle restoring divider implementing 8086-style DIV/IDIV semantics. It divides a 2·WIDTH-bit dividend by a WIDTH-bit divisor, signed or unsigned. It sits beside the combinational ALU in the execution unit; the microcode starts it, stalls on `busy`, and consumes the quotient, remainder and `error` when `done` pulses. It raises a divide error on a zero divisor or on a quotient that does not fit, for use by the INT 0 path.

## Interface
- `WIDTH`, default 16: divisor, quotient and remainder width; dividend is 2·WIDTH. Must be ≥ 4 and even.
- `BITS_PER_CYCLE`, default 1: quotient bits retired per DIVIDE cycle. Must divide WIDTH.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `is_signed`  in  1  0 = DIV, 1 = IDIV; sampled with `start`.
- `dividend`  in  2·WIDTH  sampled with `start`.
- `divisor`  in  WIDTH  sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  divide error; valid while `done` is high, held until the next `done`.
- `quotient`  out  WIDTH  result.
- `remainder`  out  WIDTH  result.

## Operation
- Let N = WIDTH/BITS_PER_CYCLE.
- States: IDLE → PREP → DIVIDE (N cycles) → FIX → IDLE.
- **IDLE:** `start`=1 registers the operands and the sign flags, then goes to PREP. `start` in any other state is ignored.
- **PREP:**
  - Take magnitudes of the dividend and divisor (two's-complement negate when `is_signed` and the MSB is set).
  - Early error if the magnitude dividend's upper WIDTH bits are ≥ the magnitude divisor. This covers divisor = 0.
  - On early error, go to IDLE with `done`=1 and `error`=1.
  - Otherwise load the partial remainder and go to DIVIDE.
- **DIVIDE:** each cycle performs BITS_PER_CYCLE restoring shift/subtract steps, MSB first. The partial remainder is WIDTH+1 bits.
- **FIX:**
  - Quotient sign = dividend sign XOR divisor sign. Remainder sign = dividend sign. Both apply only when `is_signed`.
  - Signed range check: a positive quotient must be ≤ 2^(WIDTH−1)−1; a negative quotient magnitude must be ≤ 2^(WIDTH−1)−1. A quotient of −2^(WIDTH−1) is an error (8086 behaviour).
  - Unsigned results never fail in FIX.
- On error, `quotient` and `remainder` keep their previous values. On success, both are updated in the same edge that raises `done`.
- Counter: log2(N)+1 bits, loaded with N−1 in PREP; DIVIDE exits when it reaches 0.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE, `busy`=0, `done`=0, `error`=0, `quotient`=0, `remainder`=0.
- Reset mid-operation aborts immediately. No `done` pulse is produced for the aborted operation.
- Let start be accepted at edge 0.
- `busy`=1 from edge 1 until the edge that raises `done`.
- Normal completion: `done`=1 in the cycle after edge N+2, i.e. N+3 edges after start.
- Early error: `done`=1 after edge 2.
- `done` is high for exactly one cycle. `busy`=0 in that cycle.
- A new `start` is accepted in the `done` cycle (back-to-back operation).
- `quotient`, `remainder` and `error` are registered. They do not change except at completion or reset.
- Inputs need to be stable only at the `start` edge.

## Structure
- Shared package `divider_pkg`:
  - `DivState_t` enum (IDLE, PREP, DIVIDE, FIX).
  - The divide-error constant used by the microcode to vector to INT 0.
- Sub-module `div_step`:
  - Combinational single restoring step: inputs are the partial remainder, the next dividend bit and the divisor; outputs are the new remainder and the quotient bit.
  - Chained BITS_PER_CYCLE times inside the DIVIDE datapath.
- The top level holds the FSM, counter, sign/magnitude logic and output registers.

## Test plan
- WIDTH=16, unsigned 0x0001_0000 / 0x0002 → quotient 0x8000, remainder 0x0000, `error`=0, `done` exactly 19 edges after start.
- Unsigned 0x0002_0000 / 0x0002, then a separate run with divisor 0x0000 → `error`=1, `done` after edge 2, `quotient`/`remainder` unchanged from the prior result.
- Signed 0xFFFF_FFF9 (−7) / 0x0002 → quotient 0xFFFD, remainder 0xFFFF. Signed 0x0000_0007 / 0xFFFE → quotient 0xFFFD, remainder 0x0001.
- Signed 0xFFFF_8000 / 0x0001 → `error`=1 (quotient −32768). Signed 0x0000_7FFF / 0x0001 → quotient 0x7FFF, `error`=0.
- Control behaviour:
  - `start` pulsed while `busy` → ignored, result unchanged.
  - `reset_n` low at edge 8 of a run → next cycle `busy`=0, no `done` pulse, outputs 0.
  - New `start` in the `done` cycle → second result correct.
- WIDTH=8, BITS_PER_CYCLE=2, unsigned 0x00FF / 0x10 → quotient 0x0F, remainder 0x0F, `done` 7 edges after start.
